// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline wrapped around an external combinational ALU.
// Optional operand forwarding from the result stage is enabled by ALU_EXEC_BYPASS_EN.
module alu_exec_stage #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             async_rst_n,
   input  logic             clk_en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [3:0]       in_op,
   input  logic [TAG_W-1:0] in_rd,
`ifdef ALU_EXEC_BYPASS_EN
   input  logic [TAG_W-1:0] in_rsa,
   input  logic [TAG_W-1:0] in_rsb,
`endif
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_op,
   input  logic [31:0]      alu_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_rd,
   output logic             out_illegal
);

   localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

   // S1: operand register
   logic             s1_valid;
   logic [31:0]      s1_a;
   logic [31:0]      s1_b;
   logic [3:0]       s1_op;
   logic [TAG_W-1:0] s1_rd;

   // S2: result register
   logic             s2_valid;
   logic [31:0]      s2_res;
   logic [TAG_W-1:0] s2_rd;
   logic             s2_illegal;

   logic s1_adv;
   logic accept;
   logic s1_illegal;
   logic [31:0] s2_next_res;

   assign s1_adv = s1_valid && (!s2_valid || out_ready);

   // Reset gates in_ready so nothing is accepted while the stage is held in reset.
   assign in_ready = async_rst_n && clk_en && (!s1_valid || s1_adv);
   assign accept   = in_valid && in_ready;

   // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
   always_comb begin
      s1_illegal  = 1'b0;
      s2_next_res = alu_res;
      if (s1_op > OP_LAST_LEGAL) begin
         s1_illegal  = 1'b1;
         s2_next_res = '0;
      end
   end

`ifdef ALU_EXEC_BYPASS_EN
   logic [TAG_W-1:0] s1_rsa;
   logic [TAG_W-1:0] s1_rsb;
   logic             fwd_src_ok;

   // Tag 0 is the hard-wired zero register and is never forwarded.
   assign fwd_src_ok = s2_valid && !s2_illegal;
   assign alu_a = (fwd_src_ok && (s1_rsa != '0) && (s2_rd == s1_rsa)) ? s2_res : s1_a;
   assign alu_b = (fwd_src_ok && (s1_rsb != '0) && (s2_rd == s1_rsb)) ? s2_res : s1_b;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         s1_rsa <= '0;
         s1_rsb <= '0;
      end else if (accept) begin
         s1_rsa <= in_rsa;
         s1_rsb <= in_rsb;
      end
   end
`else
   assign alu_a = s1_a;
   assign alu_b = s1_b;
`endif

   assign alu_op = s1_op;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_rd    <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= in_a;
         s1_b     <= in_b;
         s1_op    <= in_op;
         s1_rd    <= in_rd;
      end else if (clk_en && s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 refills from S1 in the same cycle it drains, keeping one op per cycle.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         s2_valid   <= 1'b0;
         s2_res     <= '0;
         s2_rd      <= '0;
         s2_illegal <= 1'b0;
      end else if (clk_en) begin
         if (s1_adv) begin
            s2_valid   <= 1'b1;
            s2_res     <= s2_next_res;
            s2_rd      <= s1_rd;
            s2_illegal <= s1_illegal;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = s2_valid;
   assign out_res     = s2_res;
   assign out_rd      = s2_rd;
   assign out_illegal = s2_illegal;

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 5, destination/source register tag width.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port async_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port clk_en  input  1  global clock enable; low = all state holds.
REQ-005 SHALL have port in_valid  input  1  upstream issue request.
REQ-006 SHALL have port in_ready  output  1  stage accepts this cycle.
REQ-007 SHALL have ports in_a, in_b  input  32 each  operands.
REQ-008 SHALL have port in_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHR, 6 ASR, 7 SHL, 8 CCH, 9 BCH.
REQ-009 SHALL have port in_rd  input  TAG_W  destination tag.
REQ-010 SHALL have ports alu_a, alu_b  output  32 each, and alu_op  output  4: drive the external alu instance.
REQ-011 SHALL have port alu_res  input  32  combinational alu result.
REQ-012 SHALL have ports out_valid  output  1, out_ready  input  1: downstream handshake.
REQ-013 SHALL have ports out_res  output  32, out_rd  output  TAG_W, out_illegal  output  1.

Function
REQ-014 Stage S1 (operand register: a, b, op, rd, valid) SHALL drive alu_a/alu_b/alu_op directly from its registers.
REQ-015 Stage S2 (result register: res, rd, illegal, valid) SHALL drive out_* directly from its registers; no combinational path from in_* to out_*.
REQ-016 Transfer on either side SHALL occur only when valid, ready and clk_en are all high in the same cycle.
REQ-017 s1_adv = s1_valid && (!s2_valid || out_ready); in_ready SHALL be clk_en && (!s1_valid || s1_adv).
REQ-018 Latency SHALL be 2 cycles accept-to-out_valid; throughput 1 op/cycle with out_ready held high.
REQ-019 Simultaneous accept and advance SHALL load S1 with new op while S2 captures old S1; neither entry lost or duplicated.
REQ-020 With out_ready low and both stages full, in_ready SHALL be 0 and all S1/S2 contents SHALL hold stable.
REQ-021 Opcodes 10-15 SHALL capture out_res=0, out_illegal=1 in S2; legal ops capture alu_res, out_illegal=0.
REQ-022 clk_en low SHALL freeze S1/S2; out_valid and out_* remain driven unchanged.

Reset
REQ-023 async_rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid=0, out_res=0, out_rd=0, out_illegal=0, alu_a=0, alu_b=0, alu_op=0.
REQ-024 Reset mid-operation SHALL discard all in-flight ops; no output transfer follows release without a new accept.
REQ-025 in_ready SHALL be 0 during reset and SHALL follow REQ-017 from the first cycle after deassertion.

Configuration
REQ-026 Macro ALU_EXEC_BYPASS_EN, when defined, SHALL add inputs in_rsa, in_rsb (TAG_W each), registered into S1.
REQ-027 With ALU_EXEC_BYPASS_EN: alu_a SHALL be s2 res when s2_valid, !s2 illegal, s2 rd==s1 rsa and rsa!=0, else s1 a; alu_b likewise with rsb.
REQ-028 Without ALU_EXEC_BYPASS_EN: in_rsa/in_rsb SHALL not exist; alu_a/alu_b SHALL always equal S1 a/b.

Verification
REQ-029 Accept ADD a=2 b=5 rd=1 at cycle 0, out_ready=1 -> out_valid at cycle 2, out_res=7, out_rd=1, out_illegal=0.
REQ-030 Back-to-back SUB 2-5, ASR 0x80000000>>2, SHL 32<<2 -> 0xFFFFFFFD, 0xE0000000, 128 on consecutive cycles.
REQ-031 out_ready=0, issue 3 ops -> 2 accepted, in_ready=0 on third, out_res stable; release out_ready -> all 3 emerge in order.
REQ-032 op=12 -> out_res=0, out_illegal=1; following ADD 1+2 -> 3, out_illegal=0.
REQ-033 Bypass build: ADD 2+5 rd=3, then SHL a=0 rsa=3 b=2 -> second result 28; with rsa=0 -> 0.
REQ-034 async_rst_n pulsed low with both stages full -> out_valid drops same cycle; no output after release until new accept.
